spi_cfg_bank: RTL and testbench

Multi-voice successor to the single-voice SPI configuration register. It oversamples an SPI mode-0 link on the system clock and decodes addressed frames into per-voice shadow registers. It commits each frame atomically on NSS deassertion and drops malformed frames, counting them. The block sits between the chip pins and the voice array (ADSR, oscillator, filter per voice) and supplies each voice's packed configuration word and trigger level.

---
 rtl/spi_cfg_bank.sv | 152 +++++++++++++++
 tb/tb_spi_cfg_bank.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_bank.sv
// Multi-voice SPI configuration bank: oversampled mode-0 receiver that decodes
// addressed frames into per-voice config words, committed atomically on NSS rise.

module spi_cfg_voice #(
  parameter int CFG_W = 60
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             ld_cfg,
  input  logic             ld_trig,
  input  logic [CFG_W-1:0] shadow,
  input  logic             trig_val,
  output logic [CFG_W-1:0] cfg,
  output logic             trig
);
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cfg  <= '0;
      trig <= 1'b0;
    end else begin
      if (ld_cfg)  cfg  <= shadow;
      if (ld_trig) trig <= trig_val;
    end
  end
endmodule

module spi_cfg_bank #(
  parameter int VOICES = 4,
  parameter int CFG_W  = 60
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic                    sck,
  input  logic                    nss,
  input  logic                    mosi,
  output logic [VOICES*CFG_W-1:0] cfg,
  output logic [VOICES-1:0]       trig,
  output logic                    progn,
  output logic                    commit,
  output logic                    err,
  output logic [7:0]              err_cnt
);
  localparam int CNT_W = $clog2(8 + CFG_W + 2);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(8);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(8 + CFG_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(8 + CFG_W + 1);

  typedef enum logic [1:0] {WAIT, IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [2:0]       sck_s, nss_s;
  logic [1:0]       mosi_s;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       hdr;
  logic [CFG_W-1:0] shd;
  logic             clr, shift_en, eval;
  logic             voice_ok, wr_ok, tg_ok, bad;

  // Two sync flops per pin; the third stage on sck/nss is for edge detection.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sck_s  <= 3'b000;
      nss_s  <= 3'b111;
      mosi_s <= 2'b00;
    end else begin
      sck_s  <= {sck_s[1:0], sck};
      nss_s  <= {nss_s[1:0], nss};
      mosi_s <= {mosi_s[0], mosi};
    end
  end

  wire sck_rise = sck_s[1] & ~sck_s[2];
  wire nss_fall = ~nss_s[1] & nss_s[2];
  wire nss_rise = nss_s[1] & ~nss_s[2];
  wire sample   = sck_rise & ~nss_s[1];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= WAIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    eval      = 1'b0;
    case (state)
      WAIT:  if (nss_s[1]) state_nxt = IDLE;
      IDLE:  if (nss_fall) begin
               state_nxt = SHIFT;
               clr       = 1'b1;
             end
      SHIFT: if (nss_rise) begin
               state_nxt = IDLE;
               eval      = 1'b1;
             end else begin
               shift_en  = sample;
             end
      default: state_nxt = WAIT;
    endcase
  end

  assign voice_ok = {1'b0, hdr[5:0]} < 7'(VOICES);
  assign wr_ok    = eval &  hdr[6] & (cnt == CNT_FULL) & voice_ok;
  assign tg_ok    = eval & ~hdr[6] & (cnt == CNT_HDR)  & voice_ok;
  assign bad      = eval & ~(wr_ok | tg_ok);

  // Header fills first; payload enters the shadow at the MSB so bit 0 ends up first-sent.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt <= '0;
      hdr <= '0;
      shd <= '0;
    end else if (clr) begin
      cnt <= '0;
      hdr <= '0;
      shd <= '0;
    end else if (shift_en) begin
      if (cnt < CNT_HDR)       hdr <= {mosi_s[1], hdr[7:1]};
      else if (cnt < CNT_FULL) shd <= {mosi_s[1], shd[CFG_W-1:1]};
      if (cnt != CNT_MAX)      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      commit  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      commit <= wr_ok | tg_ok;
      err    <= bad;
      if (bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign progn = nss_s[1];

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    wire sel = (hdr[5:0] == 6'(v));
    spi_cfg_voice #(.CFG_W(CFG_W)) u_voice (
      .clk      (clk),
      .arstn    (arstn),
      .ld_cfg   (wr_ok & sel),
      .ld_trig  ((wr_ok | tg_ok) & sel),
      .shadow   (shd),
      .trig_val (hdr[7]),
      .cfg      (cfg[v*CFG_W +: CFG_W]),
      .trig     (trig[v])
    );
  end
endmodule

// File: tb/tb_spi_cfg_bank.sv
// Directed bench for spi_cfg_bank: SPI frames driven at 1/8 of clk, outputs
// checked against hand-computed values and pulse counts.

module tb_spi_cfg_bank;
  localparam int VOICES = 4;
  localparam int CFG_W  = 60;

  logic                    clk = 1'b0;
  logic                    arstn, sck, nss, mosi;
  logic [VOICES*CFG_W-1:0] cfg;
  logic [VOICES-1:0]       trig;
  logic                    progn, commit, err;
  logic [7:0]              err_cnt;

  int total = 0;
  int bad   = 0;
  int n_commit = 0;
  int n_err    = 0;

  spi_cfg_bank #(.VOICES(VOICES), .CFG_W(CFG_W)) dut (
    .clk(clk), .arstn(arstn), .sck(sck), .nss(nss), .mosi(mosi),
    .cfg(cfg), .trig(trig), .progn(progn), .commit(commit), .err(err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (commit === 1'b1) n_commit++;
    if (err === 1'b1)    n_err++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [127:0] f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mosi = f[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [127:0] f, input int n);
    nss = 1'b0;
    #80;
    spi_bits(f, 0, n);
    #40 nss = 1'b1;
    #300;
  endtask

  localparam logic [59:0] P2 = 60'hEDC_BA98_7654_3210;
  localparam logic [59:0] P0 = 60'h123_4567_89AB_CDEF;

  logic [239:0] exp_cfg;
  int c0, e0;

  initial begin
    arstn = 1'b0; sck = 1'b0; nss = 1'b1; mosi = 1'b0;
    #40;
    chk("rst_cfg",     cfg,     '0);
    chk("rst_trig",    trig,    '0);
    chk("rst_progn",   progn,   1);
    chk("rst_commit",  commit,  0);
    chk("rst_err",     err,     0);
    chk("rst_err_cnt", err_cnt, 0);
    #10 arstn = 1'b1;
    #100;

    // write to voice 2
    c0 = n_commit; e0 = n_err;
    nss = 1'b0;
    #80;
    chk("progn_low", progn, 0);
    spi_bits({P2, 8'hC2}, 0, 68);
    #40 nss = 1'b1;
    #300;
    exp_cfg = 240'(P2) << 120;
    chk("wr_cfg",    cfg,            exp_cfg);
    chk("wr_trig",   trig,           4'b0100);
    chk("wr_commit", n_commit - c0,  1);
    chk("wr_noerr",  n_err - e0,     0);
    chk("wr_progn",  progn,          1);

    // trigger-only clears trig[2]
    c0 = n_commit;
    frame(128'h02, 8);
    chk("tg_trig",   trig,          4'b0000);
    chk("tg_cfg",    cfg,           exp_cfg);
    chk("tg_commit", n_commit - c0, 1);

    // one bit short
    c0 = n_commit; e0 = n_err;
    frame({P2 ^ 60'hFFF, 8'hC3}, 67);
    chk("short_err",    n_err - e0,    1);
    chk("short_cnt",    err_cnt,       1);
    chk("short_cfg",    cfg,           exp_cfg);
    chk("short_trig",   trig,          4'b0000);
    chk("short_commit", n_commit - c0, 0);

    // one bit long (overflow)
    e0 = n_err;
    frame({1'b1, P2 ^ 60'hF0F0, 8'hC2}, 69);
    chk("long_err",  n_err - e0, 1);
    chk("long_cnt",  err_cnt,    2);
    chk("long_cfg",  cfg,        exp_cfg);
    chk("long_trig", trig,       4'b0000);

    // voice index out of range
    c0 = n_commit; e0 = n_err;
    frame({P0, 8'hC5}, 68);
    chk("oor_err",    n_err - e0,    1);
    chk("oor_cnt",    err_cnt,       3);
    chk("oor_cfg",    cfg,           exp_cfg);
    chk("oor_trig",   trig,          4'b0000);
    chk("oor_commit", n_commit - c0, 0);

    // 300 empty frames saturate the error counter
    e0 = n_err;
    for (int k = 0; k < 300; k++) begin
      nss = 1'b0;
      #60 nss = 1'b1;
      #60;
    end
    #100;
    chk("sat_errs", n_err - e0, 300);
    chk("sat_cnt",  err_cnt,    8'hFF);
    chk("sat_cfg",  cfg,        exp_cfg);

    // reset mid-payload, released while the frame is still running
    c0 = n_commit;
    nss = 1'b0;
    #80;
    spi_bits({P0, 8'hC1}, 0, 30);
    arstn = 1'b0;
    #20;
    chk("mid_rst_cfg",   cfg,     '0);
    chk("mid_rst_trig",  trig,    '0);
    chk("mid_rst_cnt",   err_cnt, 0);
    chk("mid_rst_progn", progn,   1);
    arstn = 1'b1;
    spi_bits({P0, 8'hC1}, 30, 68);
    chk("mid_no_commit", n_commit - c0, 0);
    #40 nss = 1'b1;
    #300;
    chk("mid_after_commit", n_commit - c0, 0);
    chk("mid_after_cfg",    cfg,           '0);
    chk("mid_after_trig",   trig,          '0);

    // subsequent valid write to voice 0
    c0 = n_commit;
    frame({P0, 8'h40}, 68);
    chk("v0_cfg",    cfg,           240'(P0));
    chk("v0_trig",   trig,          4'b0000);
    chk("v0_commit", n_commit - c0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
